// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between instruction fetch and data access.
// Data wins arbitration by default; a waiting fetch is forced after MAX_DATA_STREAK data grants.
module mem_port_arbiter #(
   parameter int MEM_LATENCY     = 2,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        mem_read_ctrl,
   output logic        mem_write_ctrl,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        pipe_stall,
   output logic        busy
);

   localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
   localparam int STR_W = $clog2(MAX_DATA_STREAK + 1);
   localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(MEM_LATENCY - 1);
   localparam logic [STR_W-1:0] STREAK_MAX = STR_W'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  latCnt_q, latCnt_d;
   logic [STR_W-1:0]  streak_q, streak_d;
   logic              memRead_q, memRead_d;
   logic              memWrite_q, memWrite_d;
   logic [31:0]       memAddr_q, memAddr_d;
   logic [31:0]       memWdata_q, memWdata_d;
   logic              ifAck_q, ifAck_d;
   logic              dAck_q, dAck_d;
   logic [31:0]       ifRdata_q, ifRdata_d;
   logic [31:0]       dRdata_q, dRdata_d;
   logic              dReq, ifPend, dPend;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         latCnt_q   <= '0;
         streak_q   <= '0;
         memRead_q  <= 1'b0;
         memWrite_q <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         ifAck_q    <= 1'b0;
         dAck_q     <= 1'b0;
         ifRdata_q  <= '0;
         dRdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         latCnt_q   <= latCnt_d;
         streak_q   <= streak_d;
         memRead_q  <= memRead_d;
         memWrite_q <= memWrite_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
         ifAck_q    <= ifAck_d;
         dAck_q     <= dAck_d;
         ifRdata_q  <= ifRdata_d;
         dRdata_q   <= dRdata_d;
      end
   end

   // A port acked this cycle is retiring its request, so it is masked from arbitration.
   always_comb begin
      dReq       = d_rd | d_wr;
      ifPend     = if_req & ~ifAck_q;
      dPend      = dReq & ~dAck_q;
      state_d    = state_q;
      latCnt_d   = latCnt_q;
      streak_d   = streak_q;
      memRead_d  = memRead_q;
      memWrite_d = memWrite_q;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      ifAck_d    = 1'b0;
      dAck_d     = 1'b0;
      ifRdata_d  = ifRdata_q;
      dRdata_d   = dRdata_q;
      case (state_q)
         IDLE: begin
            if ((ifPend && (streak_q == STREAK_MAX)) || (ifPend && !dPend)) begin
               state_d    = FETCH;
               latCnt_d   = LAT_INIT;
               streak_d   = '0;
               memRead_d  = 1'b1;
               memWrite_d = 1'b0;
               memAddr_d  = if_addr;
            end else if (dPend) begin
               state_d    = DATA;
               latCnt_d   = LAT_INIT;
               memRead_d  = ~d_wr;
               memWrite_d = d_wr;
               memAddr_d  = d_addr;
               memWdata_d = d_wdata;
               if (!if_req) begin
                  streak_d = '0;
               end else if (streak_q != STREAK_MAX) begin
                  streak_d = streak_q + STR_W'(1);
               end
            end
         end
         FETCH, DATA: begin
            if (latCnt_q == '0) begin
               state_d    = IDLE;
               memRead_d  = 1'b0;
               memWrite_d = 1'b0;
               if (state_q == FETCH) begin
                  ifRdata_d = mem_rdata;
                  ifAck_d   = 1'b1;
               end else begin
                  if (memRead_q) begin
                     dRdata_d = mem_rdata;
                  end
                  dAck_d = 1'b1;
               end
            end else begin
               latCnt_d = latCnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d    = IDLE;
            memRead_d  = 1'b0;
            memWrite_d = 1'b0;
         end
      endcase
   end

   // Stall is held low during reset so every output reads 0 while rst is high.
   always_comb begin
      if_rdata       = ifRdata_q;
      if_ack         = ifAck_q;
      d_rdata        = dRdata_q;
      d_ack          = dAck_q;
      mem_read_ctrl  = memRead_q;
      mem_write_ctrl = memWrite_q;
      mem_addr       = memAddr_q;
      mem_wdata      = memWdata_q;
      busy           = (state_q != IDLE);
      pipe_stall     = ~rst & ((if_req & ~ifAck_q) | ((d_rd | d_wr) & ~dAck_q));
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model compared every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_mem_port_arbiter;

   localparam int LAT  = 2;
   localparam int MAXS = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        d_rd, d_wr;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        d_ack;
   logic        mem_read_ctrl, mem_write_ctrl;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        pipe_stall, busy;

   int compared   = 0;
   int mismatched = 0;

   mem_port_arbiter #(.MEM_LATENCY(LAT), .MAX_DATA_STREAK(MAXS)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_read_ctrl(mem_read_ctrl), .mem_write_ctrl(mem_write_ctrl),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .pipe_stall(pipe_stall), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory contents: a few fixed words, everything else a scramble of the address.
   function automatic logic [31:0] memFn(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'h0050_0093;
         32'h0000_0040: return 32'h0000_0011;
         32'h0000_0084: return 32'h1234_5678;
         default:       return {a[15:0], a[31:16]} ^ 32'h5EED_1234;
      endcase
   endfunction

   assign mem_rdata = memFn(mem_addr);

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: one access in flight, finishing LAT edges after its grant.
   bit          modelValid = 1'b0;
   int unsigned edgeNo = 0;
   int unsigned doneEdge = 0;
   bit          inFlight, isFetch, isWrite;
   bit          mIfAck, mDAck, lastIfAck, lastDAck, mRd, mWr;
   logic [31:0] mAddr, mWdata, mIfRdata, mDRdata;
   int          streak;

   always @(posedge clk) begin
      bit ifP, dP;
      edgeNo++;
      lastIfAck = mIfAck;
      lastDAck  = mDAck;
      if (rst) begin
         modelValid = 1'b1;
         inFlight = 0; isFetch = 0; isWrite = 0;
         mIfAck = 0; mDAck = 0; mRd = 0; mWr = 0;
         mAddr = '0; mWdata = '0; mIfRdata = '0; mDRdata = '0;
         streak = 0;
      end else begin
         ifP = if_req && !mIfAck;
         dP  = (d_rd || d_wr) && !mDAck;
         mIfAck = 0;
         mDAck  = 0;
         if (inFlight) begin
            if (edgeNo == doneEdge) begin
               if (isFetch) begin
                  mIfRdata = memFn(mAddr);
                  mIfAck = 1;
               end else begin
                  if (!isWrite) mDRdata = memFn(mAddr);
                  mDAck = 1;
               end
               mRd = 0; mWr = 0; inFlight = 0;
            end
         end else if ((ifP && streak == MAXS) || (ifP && !dP)) begin
            inFlight = 1; isFetch = 1; isWrite = 0;
            mAddr = if_addr; mRd = 1; mWr = 0;
            doneEdge = edgeNo + LAT;
            streak = 0;
         end else if (dP) begin
            inFlight = 1; isFetch = 0; isWrite = d_wr;
            mAddr = d_addr; mWdata = d_wdata; mRd = !d_wr; mWr = d_wr;
            doneEdge = edgeNo + LAT;
            streak = if_req ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
         end
      end
   end

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge clk) begin
      if (modelValid) begin
         checkBit("if_ack", if_ack, mIfAck);
         checkBit("d_ack", d_ack, mDAck);
         checkOutput("if_rdata", if_rdata, mIfRdata);
         checkOutput("d_rdata", d_rdata, mDRdata);
         checkBit("mem_read_ctrl", mem_read_ctrl, mRd);
         checkBit("mem_write_ctrl", mem_write_ctrl, mWr);
         checkBit("busy", busy, inFlight);
         checkBit("pipe_stall", pipe_stall,
                  !rst && ((if_req && !mIfAck) || ((d_rd || d_wr) && !mDAck)));
         if (mRd || mWr) checkOutput("mem_addr", mem_addr, mAddr);
         if (mWr) checkOutput("mem_wdata", mem_wdata, mWdata);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Requesters retire on the edge after their ack and may raise a new request at once.
   task automatic applyStimulus(input int cycles, input int pIf, input int pD);
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (lastIfAck) if_req = 1'b0;
         if (lastDAck) begin
            d_rd = 1'b0;
            d_wr = 1'b0;
         end
         if (!if_req && ($urandom % 100) < pIf) begin
            if_req  = 1'b1;
            if_addr = $urandom;
         end
         if (!(d_rd || d_wr) && ($urandom % 100) < pD) begin
            case ($urandom % 3)
               0: begin d_rd = 1'b1; d_wr = 1'b0; end
               1: begin d_rd = 1'b0; d_wr = 1'b1; end
               default: begin d_rd = 1'b1; d_wr = 1'b1; end
            endcase
            d_addr  = $urandom;
            d_wdata = $urandom;
         end
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, mismatched=%0d", mismatched);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      if_req = 1'b1; if_addr = 32'h300;
      d_rd = 1'b1; d_wr = 1'b0; d_addr = 32'h44; d_wdata = '0;

      // Reset with every request raised
      repeat (3) begin
         @(negedge clk);
         checkBit("reset busy", busy, 1'b0);
         checkBit("reset pipe_stall", pipe_stall, 1'b0);
         checkBit("reset mem_read_ctrl", mem_read_ctrl, 1'b0);
         checkBit("reset if_ack", if_ack, 1'b0);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkBit("post-reset idle", busy, 1'b0);
      checkBit("post-reset stall", pipe_stall, 1'b1);
      @(negedge clk);
      checkBit("first grant busy", busy, 1'b1);
      checkOutput("first grant addr", mem_addr, 32'h44);
      applyStimulus(12, 0, 0);

      // Single fetch
      if_req = 1'b1; if_addr = 32'h100;
      @(negedge clk);
      checkBit("fetch stall", pipe_stall, 1'b1);
      repeat (2) begin
         @(negedge clk);
         checkBit("fetch strobe", mem_read_ctrl, 1'b1);
         checkOutput("fetch addr", mem_addr, 32'h100);
      end
      @(negedge clk);
      checkBit("fetch ack", if_ack, 1'b1);
      checkOutput("fetch rdata", if_rdata, 32'h0050_0093);
      checkBit("ack-cycle stall", pipe_stall, 1'b0);
      tick();
      if_req = 1'b0;

      // Simultaneous fetch and load: data first, fetch on the edge ending d_ack
      if_req = 1'b1; if_addr = 32'h200;
      d_rd = 1'b1; d_addr = 32'h40;
      @(negedge clk);
      @(negedge clk);
      checkOutput("load addr", mem_addr, 32'h40);
      @(negedge clk);
      @(negedge clk);
      checkBit("load ack", d_ack, 1'b1);
      checkOutput("load rdata", d_rdata, 32'h11);
      checkBit("fetch waits", if_ack, 1'b0);
      tick();
      d_rd = 1'b0;
      @(negedge clk);
      checkBit("fetch after load", mem_read_ctrl, 1'b1);
      checkOutput("fetch after load addr", mem_addr, 32'h200);
      @(negedge clk);
      @(negedge clk);
      checkBit("fetch ack 3 after d_ack", if_ack, 1'b1);
      tick();
      if_req = 1'b0;

      // Store keeps d_rdata
      d_wr = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      repeat (2) begin
         @(negedge clk);
         checkBit("store strobe", mem_write_ctrl, 1'b1);
         checkBit("store no read", mem_read_ctrl, 1'b0);
         checkOutput("store addr", mem_addr, 32'h20);
         checkOutput("store wdata", mem_wdata, 32'hDEAD_BEEF);
      end
      @(negedge clk);
      checkBit("store ack", d_ack, 1'b1);
      checkOutput("store keeps d_rdata", d_rdata, 32'h11);
      tick();
      d_wr = 1'b0;

      // Both requesters saturated
      applyStimulus(40, 100, 100);
      applyStimulus(10, 0, 0);

      // Reset one cycle into a load
      d_rd = 1'b1; d_addr = 32'h80;
      @(negedge clk);
      tick();
      rst = 1'b1; d_rd = 1'b0;
      @(negedge clk);
      checkBit("load before abort", mem_read_ctrl, 1'b1);
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkBit("abort strobe", mem_read_ctrl, 1'b0);
      checkBit("abort busy", busy, 1'b0);
      repeat (5) begin
         @(negedge clk);
         checkBit("no ack after abort", d_ack, 1'b0);
      end
      tick();
      d_rd = 1'b1; d_addr = 32'h84;
      @(negedge clk);
      @(negedge clk);
      checkBit("fresh load strobe", mem_read_ctrl, 1'b1);
      @(negedge clk);
      @(negedge clk);
      checkBit("fresh load ack", d_ack, 1'b1);
      checkOutput("fresh load rdata", d_rdata, 32'h1234_5678);
      tick();
      d_rd = 1'b0;

      // Random traffic
      applyStimulus(400, 30, 30);
      applyStimulus(300, 70, 70);
      applyStimulus(20, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
